// File: rtl/bus_decode.sv
// Byte-stream packet decoder: 0x55, ADRH, ADRL, DATA, CKSUM -> one bus transaction.
// A bad checksum or an inter-byte timeout drops the packet and pulses err_o.
module bus_decode #(
    parameter logic [15:0] TIMEOUT = 16'd1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sink_stb_i,
    output logic        sink_ack_o,
    input  logic [7:0]  sink_d_i,
    output logic        source_stb_o,
    input  logic        source_ack_i,
    output logic        source_wr_o,
    output logic [13:0] source_a_o,
    output logic [7:0]  source_d_o,
    output logic        err_o,
    output logic [7:0]  err_cnt_o
);

    typedef enum logic [2:0] {
        StIdle,
        StAdrh,
        StAdrl,
        StData,
        StCksum,
        StIssue
    } state_e;

    localparam logic [7:0] SyncByte = 8'h55;

    state_e      state_q, state_d;
    logic [7:0]  adrh_q, adrh_d;
    logic [7:0]  adrl_q, adrl_d;
    logic [7:0]  data_q, data_d;
    logic [15:0] tmo_q, tmo_d;
    logic        src_stb_q, src_stb_d;
    logic        src_wr_q, src_wr_d;
    logic [13:0] src_a_q, src_a_d;
    logic [7:0]  src_d_q, src_d_d;
    logic        err_q, err_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    logic        accept;
    logic        in_packet;
    logic [7:0]  cksum;
    logic        cksum_ok;
    logic [15:0] tmo_inc;
    logic        tmo_hit;
    logic        cap_adrh, cap_adrl, cap_data, issue_load, issue_done;

    assign accept    = sink_stb_i && sink_ack_o;
    assign in_packet = (state_q == StAdrh) || (state_q == StAdrl) ||
                       (state_q == StData) || (state_q == StCksum);
    assign cksum     = SyncByte + adrh_q + adrl_q + data_q;
    assign cksum_ok  = (sink_d_i == cksum);
    assign tmo_inc   = tmo_q + 16'd1;
    // An accepted byte takes priority over an expiring timeout.
    assign tmo_hit   = (TIMEOUT != 16'd0) && in_packet && !accept && (tmo_inc == TIMEOUT);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept && (sink_d_i == SyncByte)) state_d = StAdrh;
            end
            StAdrh: begin
                if (accept) begin
                    state_d = StAdrl;
                end else if (tmo_hit) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end
            end
            StAdrl: begin
                if (accept) begin
                    state_d = StData;
                end else if (tmo_hit) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end
            end
            StData: begin
                if (accept) begin
                    state_d = StCksum;
                end else if (tmo_hit) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end
            end
            StCksum: begin
                if (accept) begin
                    if (cksum_ok) begin
                        state_d = StIssue;
                    end else begin
                        state_d = StIdle;
                        err_d   = 1'b1;
                    end
                end else if (tmo_hit) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end
            end
            StIssue: begin
                if (src_stb_q && source_ack_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs and datapath enables
    always_comb begin
        sink_ack_o = (state_q != StIssue);
        cap_adrh   = (state_q == StAdrh) && accept;
        cap_adrl   = (state_q == StAdrl) && accept;
        cap_data   = (state_q == StData) && accept;
        issue_load = (state_q == StCksum) && accept && cksum_ok;
        issue_done = (state_q == StIssue) && src_stb_q && source_ack_i;
    end

    always_comb begin
        adrh_d    = cap_adrh ? sink_d_i : adrh_q;
        adrl_d    = cap_adrl ? sink_d_i : adrl_q;
        data_d    = cap_data ? sink_d_i : data_q;

        if (in_packet && !accept && !tmo_hit) begin
            tmo_d = tmo_inc;
        end else begin
            tmo_d = 16'd0;
        end

        src_stb_d = src_stb_q;
        src_wr_d  = src_wr_q;
        src_a_d   = src_a_q;
        src_d_d   = src_d_q;
        if (issue_load) begin
            src_stb_d = 1'b1;
            src_wr_d  = adrh_q[7];
            src_a_d   = {adrh_q[5:0], adrl_q};
            src_d_d   = data_q;
        end else if (issue_done) begin
            src_stb_d = 1'b0;
        end

        err_cnt_d = err_cnt_q;
        if (err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adrh_q    <= 8'h00;
            adrl_q    <= 8'h00;
            data_q    <= 8'h00;
            tmo_q     <= 16'd0;
            src_stb_q <= 1'b0;
            src_wr_q  <= 1'b0;
            src_a_q   <= 14'd0;
            src_d_q   <= 8'h00;
            err_q     <= 1'b0;
            err_cnt_q <= 8'h00;
        end else begin
            adrh_q    <= adrh_d;
            adrl_q    <= adrl_d;
            data_q    <= data_d;
            tmo_q     <= tmo_d;
            src_stb_q <= src_stb_d;
            src_wr_q  <= src_wr_d;
            src_a_q   <= src_a_d;
            src_d_q   <= src_d_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign source_stb_o = src_stb_q;
    assign source_wr_o  = src_wr_q;
    assign source_a_o   = src_a_q;
    assign source_d_o   = src_d_q;
    assign err_o        = err_q;
    assign err_cnt_o    = err_cnt_q;

endmodule

// File: tb/tb_bus_decode.sv
// Directed bench for bus_decode: expected transactions are queued as packets are sent
// and popped by a monitor at each source handshake.
module tb_bus_decode;

    typedef struct packed {
        logic        wr;
        logic [13:0] a;
        logic [7:0]  d;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sink_stb = 1'b0;
    logic        sink_ack;
    logic [7:0]  sink_d = 8'h00;
    logic        source_stb;
    logic        source_ack = 1'b1;
    logic        source_wr;
    logic [13:0] source_a;
    logic [7:0]  source_d;
    logic        err;
    logic [7:0]  err_cnt;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int err_seen = 0;
    int stb_cyc = 0;
    int txn_seen = 0;
    int last_hs = 0;
    int prev_hs = 0;
    txn_t exp_q[$];

    bus_decode #(.TIMEOUT(16'd16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sink_stb_i  (sink_stb),
        .sink_ack_o  (sink_ack),
        .sink_d_i    (sink_d),
        .source_stb_o(source_stb),
        .source_ack_i(source_ack),
        .source_wr_o (source_wr),
        .source_a_o  (source_a),
        .source_d_o  (source_d),
        .err_o       (err),
        .err_cnt_o   (err_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: a handshake seen at the negedge completes on the following posedge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (err === 1'b1) err_seen++;
            if (source_stb === 1'b1) stb_cyc++;
            if (source_stb === 1'b1 && source_ack === 1'b1) begin
                txn_t got, want;
                got = '{wr: source_wr, a: source_a, d: source_d};
                txn_seen++;
                prev_hs = last_hs;
                last_hs = cyc;
                if (exp_q.size() == 0) begin
                    chk("unexpected_txn", {9'd0, got}, 32'hFFFF_FFFF);
                end else begin
                    want = exp_q.pop_front();
                    chk("txn", {9'd0, got}, {9'd0, want});
                end
            end
        end
    end

    task automatic send(input logic [7:0] b);
        bit got = 0;
        sink_stb = 1'b1;
        sink_d   = b;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (sink_ack === 1'b1) begin
                got = 1;
                break;
            end
        end
        if (!got) chk("sink_ack_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        sink_stb = 1'b0;
    endtask

    task automatic pkt(input logic wr, input logic x, input logic [13:0] a, input logic [7:0] d,
                       input bit good, input bit expect_txn);
        logic [7:0] adrh, ck;
        adrh = {wr, x, a[13:8]};
        ck   = 8'h55 + adrh + a[7:0] + d;
        if (!good) ck = ck ^ 8'h01;
        if (expect_txn) exp_q.push_back('{wr: wr, a: a, d: d});
        send(8'h55);
        send(adrh);
        send(a[7:0]);
        send(d);
        send(ck);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        idle(3);
        chk(tag, exp_q.size(), 0);
    endtask

    initial begin
        int e0, s0, t0;

        // Reset values while clock runs with rst_n low
        #12;
        chk("rst_stb", source_stb, 0);
        chk("rst_err", err, 0);
        chk("rst_fields", {source_wr, source_a, source_d}, 0);
        chk("rst_errcnt", err_cnt, 0);
        chk("rst_sink_ack", sink_ack, 1);
        #10 rst_n = 1'b1;
        idle(1);

        // Write packet, ack tied high
        s0 = stb_cyc;
        exp_q.push_back('{wr: 1'b1, a: 14'h0ABC, d: 8'hDE});
        send(8'h55); send(8'h8A); send(8'hBC); send(8'hDE); send(8'h79);
        drain("write_drain");
        chk("write_stb_cycles", stb_cyc - s0, 1);
        chk("write_errcnt", err_cnt, 0);

        // Read with leading junk bytes
        exp_q.push_back('{wr: 1'b0, a: 14'h0123, d: 8'h00});
        send(8'h00); send(8'hFF);
        send(8'h55); send(8'h01); send(8'h23); send(8'h00); send(8'h79);
        drain("read_drain");
        chk("read_no_err", err_seen, 0);

        // Bad checksum then a good packet; bit 6 of ADRH must be ignored
        t0 = txn_seen;
        send(8'h55); send(8'h01); send(8'h23); send(8'h00); send(8'h7A);
        idle(3);
        chk("bad_no_txn", txn_seen - t0, 0);
        chk("bad_err_pulse", err_seen, 1);
        chk("bad_errcnt", err_cnt, 1);
        pkt(1'b1, 1'b1, 14'h1F0F, 8'h55, 1'b1, 1'b1);
        drain("after_bad_drain");

        // Back-to-back rate
        pkt(1'b0, 1'b0, 14'h2AAA, 8'h3C, 1'b1, 1'b1);
        pkt(1'b1, 1'b0, 14'h0001, 8'hC3, 1'b1, 1'b1);
        drain("rate_drain");
        chk("rate_cycles", last_hs - prev_hs, 6);

        // Backpressure: transaction held stable, sink stalled
        source_ack = 1'b0;
        pkt(1'b0, 1'b0, 14'h1234, 8'h5A, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_stb", source_stb, 1);
            chk("bp_fields", {source_wr, source_a, source_d}, {1'b0, 14'h1234, 8'h5A});
            chk("bp_sink_ack", sink_ack, 0);
        end
        @(posedge clk);
        #1 source_ack = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_stb", source_stb, 0);
        chk("bp_release_sink_ack", sink_ack, 1);
        chk("bp_queue", exp_q.size(), 0);

        // Timeout after 16 idle cycles
        e0 = err_seen;
        send(8'h55); send(8'h01);
        idle(15);
        chk("tmo_not_yet", err, 0);
        idle(1);
        chk("tmo_err", err, 1);
        chk("tmo_errcnt", err_cnt, 2);
        exp_q.push_back('{wr: 1'b0, a: 14'h0123, d: 8'h00});
        send(8'h55); send(8'h01); send(8'h23); send(8'h00); send(8'h79);
        drain("tmo_recover_drain");
        chk("tmo_one_pulse", err_seen - e0, 1);

        // Byte accepted on the cycle the timeout would expire wins
        e0 = err_seen;
        exp_q.push_back('{wr: 1'b0, a: 14'h0123, d: 8'h00});
        send(8'h55); send(8'h01);
        idle(15);
        send(8'h23); send(8'h00); send(8'h79);
        drain("tmo_edge_drain");
        chk("tmo_edge_no_err", err_seen - e0, 0);

        // Saturation
        e0 = err_seen;
        for (int i = 0; i < 300; i++) pkt(1'b0, 1'b0, 14'h0000, 8'h00, 1'b0, 1'b0);
        idle(3);
        chk("sat_pulses", err_seen - e0, 300);
        chk("sat_errcnt", err_cnt, 8'hFF);

        // Reset mid-packet discards it
        t0 = txn_seen;
        send(8'h55); send(8'h8A);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_errcnt", err_cnt, 0);
        chk("arst_stb", source_stb, 0);
        #10 rst_n = 1'b1;
        idle(1);
        send(8'hBC); send(8'hDE); send(8'h79);
        idle(4);
        chk("arst_no_txn", txn_seen - t0, 0);

        // Reset during ISSUE drops the pending transaction
        source_ack = 1'b0;
        pkt(1'b1, 1'b0, 14'h3FFF, 8'hA5, 1'b1, 1'b0);
        @(negedge clk);
        chk("issue_pending", source_stb, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("issue_rst_stb", source_stb, 0);
        chk("issue_rst_fields", {source_wr, source_a, source_d}, 0);
        #10 rst_n = 1'b1;
        idle(1);
        source_ack = 1'b1;
        idle(3);
        chk("issue_rst_no_txn", txn_seen - t0, 0);
        pkt(1'b1, 1'b0, 14'h2468, 8'h11, 1'b1, 1'b1);
        drain("final_drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
